// File: rtl/branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue
//
// In-order resolution stage that sits directly behind the global predictor.
// Every prediction (pc, predicted direction, GHR snapshot) is buffered until
// the branch's real outcome arrives. Each resolve then produces one
// registered update record for the predictor's training port. A mispredict
// also discards every younger entry, raises a one-cycle history-repair pulse,
// and sends the control FSM through a single SQUASH cycle.
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous, active-high reset
//   pred_valid       predictor presents a new prediction
//   pred_ready       queue can accept a prediction (combinational)
//   pred_pc          branch PC of the prediction
//   pred_taken       predicted direction
//   pred_ghr         GHR value used to make the prediction
//   res_valid        actual outcome of the oldest branch is available
//   res_ready        queue can resolve (combinational)
//   res_taken        actual direction of the oldest branch
//   upd_valid        update record valid (one-cycle pulse per resolve)
//   upd_pc           PC of the resolved branch
//   upd_taken        actual direction of the resolved branch
//   upd_ghr          GHR snapshot of the resolved branch
//   upd_mispredict   resolved branch was mispredicted
//   flush_req        history-repair pulse (mispredicts only)
//   flush_ghr        repaired history {upd_ghr[GHR_W-2:0], upd_taken}
//   occupancy        number of live entries
//   mispredict_count saturating count of mispredicted branches
//   resolved_count   saturating count of resolved branches
// -----------------------------------------------------------------------------
module branch_resolve_queue #(
  parameter int PC_W  = 8,
  parameter int GHR_W = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_valid,
  output logic                       pred_ready,
  input  logic [PC_W-1:0]            pred_pc,
  input  logic                       pred_taken,
  input  logic [GHR_W-1:0]           pred_ghr,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic                       res_taken,
  output logic                       upd_valid,
  output logic [PC_W-1:0]            upd_pc,
  output logic                       upd_taken,
  output logic [GHR_W-1:0]           upd_ghr,
  output logic                       upd_mispredict,
  output logic                       flush_req,
  output logic [GHR_W-1:0]           flush_ghr,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_W-1:0]           mispredict_count,
  output logic [CNT_W-1:0]           resolved_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_t;

  // Control state
  state_t            state_r;
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [OCC_W-1:0]  occ_r;

  // Entry storage (pointers and occupancy qualify it, so it needs no reset)
  logic [PC_W-1:0]   pc_mem_r    [DEPTH];
  logic              taken_mem_r [DEPTH];
  logic [GHR_W-1:0]  ghr_mem_r   [DEPTH];

  // Registered outputs
  logic              upd_valid_r;
  logic [PC_W-1:0]   upd_pc_r;
  logic              upd_taken_r;
  logic [GHR_W-1:0]  upd_ghr_r;
  logic              upd_mispredict_r;
  logic              flush_req_r;
  logic [GHR_W-1:0]  flush_ghr_r;
  logic [CNT_W-1:0]  mis_cnt_r;
  logic [CNT_W-1:0]  res_cnt_r;

  // Combinational handshake / next-state signals
  logic              pred_ready_s;
  logic              res_ready_s;
  logic              enq_s;
  logic              res_s;
  logic              mispredict_s;
  logic [PC_W-1:0]   head_pc_s;
  logic              head_taken_s;
  logic [GHR_W-1:0]  head_ghr_s;
  logic [PTR_W-1:0]  tail_inc_s;
  logic [PTR_W-1:0]  head_inc_s;
  logic [PTR_W-1:0]  head_nxt_s;
  logic [PTR_W-1:0]  tail_nxt_s;
  logic [OCC_W-1:0]  occ_nxt_s;

  // Ready flags: both held low during SQUASH; full/empty come from occ_r only.
  always_comb begin
    pred_ready_s = 1'b0;
    res_ready_s  = 1'b0;
    case (state_r)
      ST_RUN: begin
        pred_ready_s = (occ_r != OCC_FULL);
        res_ready_s  = (occ_r != {OCC_W{1'b0}});
      end
      ST_SQUASH: begin
        pred_ready_s = 1'b0;
        res_ready_s  = 1'b0;
      end
      default: begin
        pred_ready_s = 1'b0;
        res_ready_s  = 1'b0;
      end
    endcase
  end

  assign enq_s        = pred_valid & pred_ready_s;
  assign res_s        = res_valid & res_ready_s;
  assign head_pc_s    = pc_mem_r[head_r];
  assign head_taken_s = taken_mem_r[head_r];
  assign head_ghr_s   = ghr_mem_r[head_r];
  assign mispredict_s = res_s & (res_taken != head_taken_s);

  // DEPTH is a power of two, so the natural PTR_W-bit wrap is the modulo.
  assign tail_inc_s = enq_s ? (tail_r + PTR_ONE) : tail_r;
  assign head_inc_s = res_s ? (head_r + PTR_ONE) : head_r;

  // Pointer and occupancy next-state; a mispredict empties the queue and
  // also drops a same-cycle enqueue by parking head on the advanced tail.
  always_comb begin
    head_nxt_s = head_r;
    tail_nxt_s = tail_r;
    occ_nxt_s  = occ_r;
    if (mispredict_s) begin
      head_nxt_s = tail_inc_s;
      tail_nxt_s = tail_inc_s;
      occ_nxt_s  = {OCC_W{1'b0}};
    end else begin
      head_nxt_s = head_inc_s;
      tail_nxt_s = tail_inc_s;
      if (enq_s && !res_s) begin
        occ_nxt_s = occ_r + OCC_ONE;
      end else if (!enq_s && res_s) begin
        occ_nxt_s = occ_r - OCC_ONE;
      end else begin
        occ_nxt_s = occ_r;
      end
    end
  end

  // Entry write port at the tail.
  always_ff @(posedge clk) begin
    if (!reset && enq_s) begin
      pc_mem_r[tail_r]    <= pred_pc;
      taken_mem_r[tail_r] <= pred_taken;
      ghr_mem_r[tail_r]   <= pred_ghr;
    end
  end

  // FSM, pointers, update record and statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= ST_RUN;
      head_r           <= {PTR_W{1'b0}};
      tail_r           <= {PTR_W{1'b0}};
      occ_r            <= {OCC_W{1'b0}};
      upd_valid_r      <= 1'b0;
      upd_pc_r         <= {PC_W{1'b0}};
      upd_taken_r      <= 1'b0;
      upd_ghr_r        <= {GHR_W{1'b0}};
      upd_mispredict_r <= 1'b0;
      flush_req_r      <= 1'b0;
      flush_ghr_r      <= {GHR_W{1'b0}};
      mis_cnt_r        <= {CNT_W{1'b0}};
      res_cnt_r        <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_RUN:    state_r <= mispredict_s ? ST_SQUASH : ST_RUN;
        ST_SQUASH: state_r <= ST_RUN;
        default:   state_r <= ST_RUN;
      endcase

      head_r <= head_nxt_s;
      tail_r <= tail_nxt_s;
      occ_r  <= occ_nxt_s;

      upd_valid_r <= res_s;
      flush_req_r <= mispredict_s;

      // Record fields only change on a resolve and hold otherwise.
      if (res_s) begin
        upd_pc_r         <= head_pc_s;
        upd_taken_r      <= res_taken;
        upd_ghr_r        <= head_ghr_s;
        upd_mispredict_r <= mispredict_s;
        flush_ghr_r      <= {head_ghr_s[GHR_W-2:0], res_taken};
        if (res_cnt_r != CNT_MAX) begin
          res_cnt_r <= res_cnt_r + CNT_ONE;
        end
        if (mispredict_s && (mis_cnt_r != CNT_MAX)) begin
          mis_cnt_r <= mis_cnt_r + CNT_ONE;
        end
      end
    end
  end

  assign pred_ready       = pred_ready_s;
  assign res_ready        = res_ready_s;
  assign upd_valid        = upd_valid_r;
  assign upd_pc           = upd_pc_r;
  assign upd_taken        = upd_taken_r;
  assign upd_ghr          = upd_ghr_r;
  assign upd_mispredict   = upd_mispredict_r;
  assign flush_req        = flush_req_r;
  assign flush_ghr        = flush_ghr_r;
  assign occupancy        = occ_r;
  assign mispredict_count = mis_cnt_r;
  assign resolved_count   = res_cnt_r;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_queue
//
// Self-checking bench: a queue-based reference model tracks the in-flight
// branches and expected outputs; every cycle all DUT outputs are compared to
// it. Directed scenarios add literal expectations, then a randomized phase
// runs with occasional resets. A small counter width makes saturation reachable.
// -----------------------------------------------------------------------------
module tb_branch_resolve_queue;

  localparam int PC_W  = 8;
  localparam int GHR_W = 8;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam longint CNT_MAX = (64'sd1 <<< CNT_W) - 64'sd1;

  logic              clk = 1'b0;
  logic              reset;
  logic              pred_valid;
  logic              pred_ready;
  logic [PC_W-1:0]   pred_pc;
  logic              pred_taken;
  logic [GHR_W-1:0]  pred_ghr;
  logic              res_valid;
  logic              res_ready;
  logic              res_taken;
  logic              upd_valid;
  logic [PC_W-1:0]   upd_pc;
  logic              upd_taken;
  logic [GHR_W-1:0]  upd_ghr;
  logic              upd_mispredict;
  logic              flush_req;
  logic [GHR_W-1:0]  flush_ghr;
  logic [OCC_W-1:0]  occupancy;
  logic [CNT_W-1:0]  mispredict_count;
  logic [CNT_W-1:0]  resolved_count;

  always #5 clk = ~clk;

  branch_resolve_queue #(
    .PC_W(PC_W), .GHR_W(GHR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .pred_ghr(pred_ghr),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_ghr(upd_ghr), .upd_mispredict(upd_mispredict),
    .flush_req(flush_req), .flush_ghr(flush_ghr), .occupancy(occupancy),
    .mispredict_count(mispredict_count), .resolved_count(resolved_count)
  );

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic             taken;
    logic [GHR_W-1:0] ghr;
  } entry_t;

  // Reference model state
  entry_t          mq[$];
  bit              m_squash;
  bit              m_upd_valid;
  logic [PC_W-1:0] m_upd_pc;
  bit              m_upd_taken;
  logic [GHR_W-1:0] m_upd_ghr;
  bit              m_upd_mis;
  bit              m_flush_req;
  logic [GHR_W-1:0] m_flush_ghr;
  longint          m_res_cnt;
  longint          m_mis_cnt;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_step();
    bit p_rdy, r_rdy, enq, res, mis;
    entry_t h, e;
    if (reset) begin
      mq.delete();
      m_squash = 0; m_upd_valid = 0; m_upd_pc = '0; m_upd_taken = 0;
      m_upd_ghr = '0; m_upd_mis = 0; m_flush_req = 0; m_flush_ghr = '0;
      m_res_cnt = 0; m_mis_cnt = 0;
    end else begin
      p_rdy = !m_squash && (mq.size() != DEPTH);
      r_rdy = !m_squash && (mq.size() != 0);
      enq = pred_valid && p_rdy;
      res = res_valid && r_rdy;
      mis = 0;
      m_upd_valid = res;
      if (res) begin
        h = mq[0];
        mis = (res_taken != h.taken);
        m_upd_pc = h.pc;
        m_upd_taken = res_taken;
        m_upd_ghr = h.ghr;
        m_upd_mis = mis;
        m_flush_ghr = GHR_W'((h.ghr << 1) | GHR_W'(res_taken));
        if (m_res_cnt < CNT_MAX) m_res_cnt++;
        if (mis && m_mis_cnt < CNT_MAX) m_mis_cnt++;
      end
      m_flush_req = res && mis;
      m_squash = res && mis;
      if (res && mis) begin
        mq.delete();
      end else begin
        if (res) void'(mq.pop_front());
        if (enq) begin
          e.pc = pred_pc; e.taken = pred_taken; e.ghr = pred_ghr;
          mq.push_back(e);
        end
      end
    end
  endtask

  // Full output comparison against the model.
  task automatic compare_all();
    check("pred_ready", longint'(pred_ready), longint'(!m_squash && mq.size() != DEPTH));
    check("res_ready", longint'(res_ready), longint'(!m_squash && mq.size() != 0));
    check("occupancy", longint'(occupancy), longint'(mq.size()));
    check("upd_valid", longint'(upd_valid), longint'(m_upd_valid));
    check("upd_pc", longint'(upd_pc), longint'(m_upd_pc));
    check("upd_taken", longint'(upd_taken), longint'(m_upd_taken));
    check("upd_ghr", longint'(upd_ghr), longint'(m_upd_ghr));
    check("upd_mispredict", longint'(upd_mispredict), longint'(m_upd_mis));
    check("flush_req", longint'(flush_req), longint'(m_flush_req));
    check("flush_ghr", longint'(flush_ghr), longint'(m_flush_ghr));
    check("resolved_count", longint'(resolved_count), m_res_cnt);
    check("mispredict_count", longint'(mispredict_count), m_mis_cnt);
  endtask

  // Drive one cycle of inputs (at negedge), clock it, then compare at negedge.
  task automatic cycle(input bit rst, input bit pv, input logic [7:0] pc,
                       input bit pt, input logic [7:0] ghr,
                       input bit rv, input bit rt);
    reset = rst; pred_valid = pv; pred_pc = pc; pred_taken = pt;
    pred_ghr = ghr; res_valid = rv; res_taken = rt;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic enq(input logic [7:0] pc, input bit pt, input logic [7:0] ghr);
    cycle(1'b0, 1'b1, pc, pt, ghr, 1'b0, 1'b0);
  endtask

  task automatic resolve(input bit rt);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, rt);
  endtask

  initial begin
    bit pv, rv, rt, rst;
    @(negedge clk);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset then idle
    for (int i = 0; i < 5; i++) begin
      idle();
      check("lit_idle_upd_valid", longint'(upd_valid), 0);
    end
    check("lit_idle_occ", longint'(occupancy), 0);
    check("lit_idle_pred_ready", longint'(pred_ready), 1);
    check("lit_idle_res_ready", longint'(res_ready), 0);
    check("lit_idle_res_cnt", longint'(resolved_count), 0);
    check("lit_idle_mis_cnt", longint'(mispredict_count), 0);

    // Three in-order correct resolves
    enq(8'h10, 1'b1, 8'h00);
    enq(8'h11, 1'b0, 8'h01);
    enq(8'h12, 1'b1, 8'h02);
    check("lit_occ3", longint'(occupancy), 3);
    resolve(1'b1);
    check("lit_upd0_valid", longint'(upd_valid), 1);
    check("lit_upd0_pc", longint'(upd_pc), 8'h10);
    resolve(1'b0);
    check("lit_upd1_pc", longint'(upd_pc), 8'h11);
    resolve(1'b1);
    check("lit_upd2_pc", longint'(upd_pc), 8'h12);
    idle();
    check("lit_upd_pulse_end", longint'(upd_valid), 0);
    check("lit_res_cnt3", longint'(resolved_count), 3);
    check("lit_mis_cnt0", longint'(mispredict_count), 0);

    // Fill/drain three laps to wrap the pointers
    for (int lap = 0; lap < 3; lap++) begin
      for (int i = 0; i < DEPTH; i++) enq(8'(8'h40 + lap * 8 + i), 1'b1, 8'(i));
      check("lit_full_occ", longint'(occupancy), DEPTH);
      check("lit_full_pred_ready", longint'(pred_ready), 0);
      enq(8'hEE, 1'b1, 8'hEE);
      enq(8'hEE, 1'b1, 8'hEE);
      check("lit_held_occ", longint'(occupancy), DEPTH);
      cycle(1'b0, 1'b1, 8'hEE, 1'b1, 8'hEE, 1'b1, 1'b1);
      check("lit_after_full_ready", longint'(pred_ready), 1);
      check("lit_lap_first_pc", longint'(upd_pc), 8'h40 + lap * 8);
      for (int i = 1; i < DEPTH; i++) begin
        resolve(1'b1);
        check("lit_lap_pc", longint'(upd_pc), 8'h40 + lap * 8 + i);
      end
    end
    check("lit_res_cnt_sat", longint'(resolved_count), CNT_MAX);

    // Mispredict with flush
    enq(8'h20, 1'b1, 8'hA5);
    for (int i = 1; i < 5; i++) enq(8'(8'h20 + i), 1'b1, 8'(i));
    resolve(1'b0);
    check("lit_mis_upd_pc", longint'(upd_pc), 8'h20);
    check("lit_mis_flag", longint'(upd_mispredict), 1);
    check("lit_mis_flush_req", longint'(flush_req), 1);
    check("lit_mis_flush_ghr", longint'(flush_ghr), 8'h4A);
    check("lit_mis_occ", longint'(occupancy), 0);
    check("lit_squash_pred_ready", longint'(pred_ready), 0);
    check("lit_squash_res_ready", longint'(res_ready), 0);
    idle();
    check("lit_run_pred_ready", longint'(pred_ready), 1);
    check("lit_flush_pulse_end", longint'(flush_req), 0);
    check("lit_mis_cnt1", longint'(mispredict_count), 1);

    // Mispredict concurrent with an enqueue that must be dropped
    enq(8'h40, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h30, 1'b1, 8'h30, 1'b1, 1'b0);
    check("lit_drop_occ", longint'(occupancy), 0);
    idle();
    check("lit_drop_occ2", longint'(occupancy), 0);
    enq(8'h31, 1'b1, 8'h31);
    resolve(1'b1);
    check("lit_drop_next_pc", longint'(upd_pc), 8'h31);

    // Reset mid-operation overrides handshakes
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    enq(8'h50, 1'b1, 8'h00);
    resolve(1'b0);
    idle();
    enq(8'h51, 1'b1, 8'h00);
    enq(8'h52, 1'b0, 8'h00);
    resolve(1'b1);
    resolve(1'b0);
    check("lit_pre_rst_res", longint'(resolved_count), 3);
    check("lit_pre_rst_mis", longint'(mispredict_count), 1);
    for (int i = 0; i < 4; i++) enq(8'(8'h60 + i), 1'b1, 8'h00);
    check("lit_pre_rst_occ", longint'(occupancy), 4);
    cycle(1'b1, 1'b1, 8'h70, 1'b1, 8'h00, 1'b1, 1'b0);
    check("lit_rst_occ", longint'(occupancy), 0);
    check("lit_rst_res", longint'(resolved_count), 0);
    check("lit_rst_mis", longint'(mispredict_count), 0);
    check("lit_rst_upd_valid", longint'(upd_valid), 0);
    idle();
    check("lit_post_rst_upd_valid", longint'(upd_valid), 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 249) == 0);
      pv  = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 2) != 0);
      if (mq.size() != 0 && $urandom_range(0, 4) != 0) rt = mq[0].taken;
      else rt = $urandom_range(0, 1) != 0;
      cycle(rst, pv, 8'($urandom), $urandom_range(0, 1) != 0, 8'($urandom), rv, rt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
